// File: rtl/d_sraml2axi_pkg.sv
`default_nettype none
// ============================================================================
// Module   : d_sraml2axi_pkg
// Brief    : Shared types and AXI tie-off constants for the SRAM-like to AXI bridge.
// Revision : 1.0
// ============================================================================
package d_sraml2axi_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_RD_AR  = 3'd1,
        ST_RD_R   = 3'd2,
        ST_WR_AWW = 3'd3,
        ST_WR_B   = 3'd4
    } state_e;

    localparam logic [3:0] C_AXI_LEN_SINGLE  = 4'd0;
    localparam logic [1:0] C_AXI_BURST_INCR  = 2'b01;
    localparam logic [1:0] C_AXI_LOCK_NORMAL = 2'b00;
    localparam logic [3:0] C_AXI_CACHE_NONE  = 4'b0000;
    localparam logic [2:0] C_AXI_PROT_NONE   = 3'b000;

    localparam logic [1:0] C_SIZE_BYTE = 2'd0;
    localparam logic [1:0] C_SIZE_HALF = 2'd1;
    localparam logic [1:0] C_SIZE_WORD = 2'd2;

endpackage
`default_nettype wire

// File: rtl/d_sraml2axi.sv
`default_nettype none
// ============================================================================
// Module   : d_sraml2axi
// Brief    : Single-outstanding bridge from an SRAM-like request port to AXI.
// Revision : 1.0
// ============================================================================
module d_sraml2axi
    import d_sraml2axi_pkg::*;
#(
    parameter logic [3:0] AXI_ID = 4'd1
) (
    input  logic        clk,
    input  logic        rst,

    input  logic        data_req,
    input  logic        data_wr,
    input  logic [1:0]  data_size,
    input  logic [31:0] data_addr,
    input  logic [31:0] data_wdata,
    output logic [31:0] data_rdata,
    output logic        data_addr_ok,
    output logic        data_data_ok,

    output logic [3:0]  arid,
    output logic [31:0] araddr,
    output logic [3:0]  arlen,
    output logic [2:0]  arsize,
    output logic [1:0]  arburst,
    output logic [1:0]  arlock,
    output logic [3:0]  arcache,
    output logic [2:0]  arprot,
    output logic        arvalid,
    input  logic        arready,

    input  logic [31:0] rdata,
    input  logic        rvalid,
    input  logic        rlast,
    output logic        rready,

    output logic [3:0]  awid,
    output logic [31:0] awaddr,
    output logic [3:0]  awlen,
    output logic [2:0]  awsize,
    output logic [1:0]  awburst,
    output logic [1:0]  awlock,
    output logic [3:0]  awcache,
    output logic [2:0]  awprot,
    output logic        awvalid,
    input  logic        awready,

    output logic [3:0]  wid,
    output logic [31:0] wdata,
    output logic [3:0]  wstrb,
    output logic        wlast,
    output logic        wvalid,
    input  logic        wready,

    input  logic        bvalid,
    output logic        bready
);

    function automatic logic [3:0] f_wstrb(input logic [1:0] size, input logic [1:0] addr_lo);
        logic [3:0] strb;
        case (size)
            C_SIZE_BYTE: strb = 4'b0001 << addr_lo;
            C_SIZE_HALF: strb = addr_lo[1] ? 4'b1100 : 4'b0011;
            default:     strb = 4'b1111;
        endcase
        return strb;
    endfunction

    state_e      r_state;
    state_e      w_state_nxt;
    logic [31:0] r_addr;
    logic [1:0]  r_size;
    logic        r_wr;
    logic [31:0] r_wdata;
    logic        r_aw_done;
    logic        r_w_done;

    logic        w_accept;
    logic        w_aw_fire;
    logic        w_w_fire;
    logic        w_aww_done;
    logic        w_unused_rlast;

    // Single-beat transfers only, so the last flag carries no information.
    assign w_unused_rlast = rlast;

    // Every handshake output is forced low while reset is held, even though
    // the state register only clears on the next edge.
    assign data_addr_ok = !rst && (r_state == ST_IDLE) && data_req;
    assign arvalid      = !rst && (r_state == ST_RD_AR);
    assign rready       = !rst && (r_state == ST_RD_R);
    assign awvalid      = !rst && (r_state == ST_WR_AWW) && !r_aw_done;
    assign wvalid       = !rst && (r_state == ST_WR_AWW) && !r_w_done;
    assign bready       = !rst && (r_state == ST_WR_B);
    assign data_data_ok = r_wr ? (bready && bvalid) : (rready && rvalid);
    assign data_rdata   = rdata;

    assign w_accept   = data_addr_ok;
    assign w_aw_fire  = awvalid && awready;
    assign w_w_fire   = wvalid && wready;
    assign w_aww_done = (r_aw_done || w_aw_fire) && (r_w_done || w_w_fire);

    assign arid    = AXI_ID;
    assign araddr  = r_addr;
    assign arlen   = C_AXI_LEN_SINGLE;
    assign arsize  = {1'b0, r_size};
    assign arburst = C_AXI_BURST_INCR;
    assign arlock  = C_AXI_LOCK_NORMAL;
    assign arcache = C_AXI_CACHE_NONE;
    assign arprot  = C_AXI_PROT_NONE;

    assign awid    = AXI_ID;
    assign awaddr  = r_addr;
    assign awlen   = C_AXI_LEN_SINGLE;
    assign awsize  = {1'b0, r_size};
    assign awburst = C_AXI_BURST_INCR;
    assign awlock  = C_AXI_LOCK_NORMAL;
    assign awcache = C_AXI_CACHE_NONE;
    assign awprot  = C_AXI_PROT_NONE;

    assign wid     = AXI_ID;
    assign wdata   = r_wdata;
    assign wstrb   = f_wstrb(r_size, r_addr[1:0]);
    assign wlast   = 1'b1;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE:   if (data_req) w_state_nxt = data_wr ? ST_WR_AWW : ST_RD_AR;
            ST_RD_AR:  if (arready)    w_state_nxt = ST_RD_R;
            ST_RD_R:   if (rvalid)     w_state_nxt = ST_IDLE;
            ST_WR_AWW: if (w_aww_done) w_state_nxt = ST_WR_B;
            ST_WR_B:   if (bvalid)     w_state_nxt = ST_IDLE;
            default:   w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_addr    <= 32'h0;
            r_size    <= 2'd0;
            r_wr      <= 1'b0;
            r_wdata   <= 32'h0;
            r_aw_done <= 1'b0;
            r_w_done  <= 1'b0;
        end else begin
            if (w_accept) begin
                r_addr  <= data_addr;
                r_size  <= data_size;
                r_wr    <= data_wr;
                r_wdata <= data_wdata;
            end
            // Done flags live only for the duration of one write address/data phase.
            if (r_state == ST_WR_AWW) begin
                if (w_aww_done) begin
                    r_aw_done <= 1'b0;
                    r_w_done  <= 1'b0;
                end else begin
                    if (w_aw_fire) r_aw_done <= 1'b1;
                    if (w_w_fire)  r_w_done  <= 1'b1;
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_d_sraml2axi.sv
`default_nettype none
// ============================================================================
// Module   : tb_d_sraml2axi
// Brief    : Scoreboard bench for d_sraml2axi with a delay-programmable AXI slave.
// Revision : 1.0
// ============================================================================
module tb_d_sraml2axi;

    logic        clk = 1'b0;
    logic        rst;
    logic        data_req, data_wr;
    logic [1:0]  data_size;
    logic [31:0] data_addr, data_wdata, data_rdata;
    logic        data_addr_ok, data_data_ok;
    logic [3:0]  arid, arlen, arcache, awid, awlen, awcache, wid, wstrb;
    logic [31:0] araddr, awaddr, wdata, rdata;
    logic [2:0]  arsize, arprot, awsize, awprot;
    logic [1:0]  arburst, arlock, awburst, awlock;
    logic        arvalid, arready, rvalid, rlast, rready;
    logic        awvalid, awready, wlast, wvalid, wready, bvalid, bready;

    d_sraml2axi dut (
        .clk(clk), .rst(rst),
        .data_req(data_req), .data_wr(data_wr), .data_size(data_size),
        .data_addr(data_addr), .data_wdata(data_wdata), .data_rdata(data_rdata),
        .data_addr_ok(data_addr_ok), .data_data_ok(data_data_ok),
        .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
        .arlock(arlock), .arcache(arcache), .arprot(arprot), .arvalid(arvalid), .arready(arready),
        .rdata(rdata), .rvalid(rvalid), .rlast(rlast), .rready(rready),
        .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awburst(awburst),
        .awlock(awlock), .awcache(awcache), .awprot(awprot), .awvalid(awvalid), .awready(awready),
        .wid(wid), .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
        .bvalid(bvalid), .bready(bready)
    );

    always #5 clk = ~clk;

    typedef struct { logic [31:0] addr; logic [2:0] size; } addr_t;
    typedef struct { logic [31:0] data; logic [3:0] strb; } wbeat_t;
    typedef struct { logic wr; logic [31:0] rdata; int lat; } done_t;

    addr_t  ar_q[$];
    addr_t  aw_q[$];
    wbeat_t w_q[$];
    done_t  d_q[$];

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;
    int acc_cyc  = 0;
    int last_done_cyc = 0;
    int acc_gap  = 0;
    int done_cnt = 0;
    int addr_ok_cnt = 0;
    int ar_hs_cnt = 0;
    bit busy = 0;

    int ar_delay = 0, r_delay = 0, aw_delay = 0, w_delay = 0, b_delay = 0;
    logic [31:0] rd_value = 32'h0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h at cycle %0d", name, act, exp, cyc);
    endtask

    task automatic fail(input string name);
        n_checks++;
        $display("FAIL %s: got event-missing expected event at cycle %0d", name, cyc);
    endtask

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // Scoreboard monitor: every DUT output is judged at the falling edge.
    initial forever begin
        @(negedge clk);
        if (rst) begin
            chk("rst_outputs_low",
                {25'h0, arvalid, rready, awvalid, wvalid, bready, data_addr_ok, data_data_ok}, 32'h0);
            busy = 0;
        end else begin
            if (data_addr_ok) begin
                chk("addr_ok_only_when_free", {31'h0, busy}, 32'h0);
                busy = 1;
                acc_gap = cyc - last_done_cyc;
                acc_cyc = cyc;
                addr_ok_cnt++;
            end
            if (arvalid) begin
                if (ar_q.size() == 0) fail("ar_unexpected_valid");
                else begin
                    chk("araddr", araddr, ar_q[0].addr);
                    chk("arsize", {29'h0, arsize}, {29'h0, ar_q[0].size});
                    if (arready) begin
                        void'(ar_q.pop_front());
                        ar_hs_cnt++;
                    end
                end
            end
            if (awvalid) begin
                if (aw_q.size() == 0) fail("aw_unexpected_valid");
                else begin
                    chk("awaddr", awaddr, aw_q[0].addr);
                    chk("awsize", {29'h0, awsize}, {29'h0, aw_q[0].size});
                    if (awready) void'(aw_q.pop_front());
                end
            end
            if (wvalid) begin
                if (w_q.size() == 0) fail("w_unexpected_valid");
                else begin
                    chk("wdata", wdata, w_q[0].data);
                    chk("wstrb", {28'h0, wstrb}, {28'h0, w_q[0].strb});
                    chk("wlast", {31'h0, wlast}, 32'h1);
                    if (wready) void'(w_q.pop_front());
                end
            end
            if (data_data_ok) begin
                if (d_q.size() == 0) fail("data_ok_unexpected");
                else begin
                    done_t e;
                    e = d_q.pop_front();
                    if (e.wr) chk("data_ok_with_b_handshake", {31'h0, bvalid & bready}, 32'h1);
                    else begin
                        chk("data_ok_with_r_handshake", {31'h0, rvalid & rready}, 32'h1);
                        chk("data_rdata", data_rdata, e.rdata);
                    end
                    if (e.lat >= 0) chk("latency", cyc - acc_cyc, e.lat);
                end
                busy = 0;
                last_done_cyc = cyc;
                done_cnt++;
            end
        end
    end

    // AXI slave: handshakes are sampled at negedge, responses driven 2 time units after posedge.
    initial begin
        bit s_rst, s_ar, s_r, s_aw, s_w, s_b;
        bit r_pend, aw_seen, w_seen, b_pend;
        int ar_cnt, r_cnt, aw_cnt, w_cnt, b_cnt;
        arready = 0; rvalid = 0; rdata = 0; rlast = 0;
        awready = 0; wready = 0; bvalid = 0;
        r_pend = 0; aw_seen = 0; w_seen = 0; b_pend = 0;
        ar_cnt = 0; r_cnt = 0; aw_cnt = 0; w_cnt = 0; b_cnt = 0;
        forever begin
            @(negedge clk);
            s_rst = rst;
            s_ar = arvalid && arready;  s_r = rvalid && rready;
            s_aw = awvalid && awready;  s_w = wvalid && wready;
            s_b  = bvalid && bready;
            @(posedge clk);
            #2;
            if (s_rst) begin
                r_pend = 0; aw_seen = 0; w_seen = 0; b_pend = 0;
                ar_cnt = 0; r_cnt = 0; aw_cnt = 0; w_cnt = 0; b_cnt = 0;
                arready = 0; rvalid = 0; rdata = 0; rlast = 0;
                awready = 0; wready = 0; bvalid = 0;
            end else begin
                if (s_ar) begin ar_cnt = 0; r_pend = 1; r_cnt = 0; end
                if (s_r)  r_pend = 0;
                if (s_aw) begin aw_cnt = 0; aw_seen = 1; end
                if (s_w)  begin w_cnt = 0; w_seen = 1; end
                if (s_b)  b_pend = 0;
                if (aw_seen && w_seen) begin aw_seen = 0; w_seen = 0; b_pend = 1; b_cnt = 0; end

                arready = arvalid && (ar_cnt >= ar_delay);
                if (arvalid && !arready) ar_cnt++;
                rvalid = r_pend && (r_cnt >= r_delay);
                rdata  = rvalid ? rd_value : 32'h0;
                rlast  = rvalid;
                if (r_pend && !rvalid) r_cnt++;
                awready = awvalid && (aw_cnt >= aw_delay);
                if (awvalid && !awready) aw_cnt++;
                wready = wvalid && (w_cnt >= w_delay);
                if (wvalid && !wready) w_cnt++;
                bvalid = b_pend && (b_cnt >= b_delay);
                if (b_pend && !bvalid) b_cnt++;
            end
        end
    end

    task automatic issue(input logic wr, input logic [1:0] size, input logic [31:0] addr,
                         input logic [31:0] wd, input logic [3:0] exp_strb,
                         input logic [31:0] exp_rdata, input int exp_lat, input bit hold);
        bit got;
        addr_t a;
        wbeat_t w;
        done_t d;
        data_req = 1; data_wr = wr; data_size = size; data_addr = addr; data_wdata = wd;
        got = 0;
        for (int i = 0; i < 50 && !got; i++) begin
            @(negedge clk);
            if (data_addr_ok) got = 1;
        end
        if (!got) begin
            fail("addr_ok_timeout");
            data_req = 0;
            return;
        end
        a.addr = addr; a.size = {1'b0, size};
        if (wr) begin
            aw_q.push_back(a);
            w.data = wd; w.strb = exp_strb;
            w_q.push_back(w);
        end else begin
            ar_q.push_back(a);
        end
        d.wr = wr; d.rdata = exp_rdata; d.lat = exp_lat;
        d_q.push_back(d);
        @(posedge clk);
        #1;
        if (!hold) data_req = 0;
    endtask

    task automatic wait_done(input string name);
        int start;
        bit seen;
        start = done_cnt;
        seen = 0;
        for (int i = 0; i < 60 && !seen; i++) begin
            @(negedge clk);
            #1;
            if (done_cnt != start) seen = 1;
        end
        if (!seen) fail(name);
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: got no finish expected finish before time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int ok0, ar0, dn0;
        rst = 1; data_req = 0; data_wr = 0; data_size = 0; data_addr = 0; data_wdata = 0;
        repeat (3) @(posedge clk);
        #1 rst = 0;

        // Reset state and constant tie-offs.
        @(negedge clk);
        chk("idle_outputs_low",
            {25'h0, arvalid, rready, awvalid, wvalid, bready, data_addr_ok, data_data_ok}, 32'h0);
        chk("arid", {28'h0, arid}, 32'h1);
        chk("awid", {28'h0, awid}, 32'h1);
        chk("wid",  {28'h0, wid},  32'h1);
        chk("arlen_awlen", {24'h0, arlen, awlen}, 32'h0);
        chk("arburst_awburst", {28'h0, arburst, awburst}, 32'h5);
        chk("lock_cache_prot", {8'h0, arlock, awlock, arcache, awcache, arprot, awprot}, 32'h0);
        chk("araddr_reset", araddr, 32'h0);

        // Word read, zero-wait slave.
        @(posedge clk); #1;
        ar_delay = 0; r_delay = 0; rd_value = 32'hDEADBEEF;
        issue(0, 2'd2, 32'h1FC0_0000, 32'h0, 4'h0, 32'hDEADBEEF, 2, 0);
        wait_done("read_word_timeout");

        // Byte write to lane 3.
        aw_delay = 0; w_delay = 0; b_delay = 0;
        issue(1, 2'd0, 32'h0000_0003, 32'h1100_0000, 4'b1000, 32'h0, 2, 0);
        wait_done("write_byte3_timeout");

        // Byte write to lane 1.
        issue(1, 2'd0, 32'h0000_0101, 32'h0000_5500, 4'b0010, 32'h0, 2, 0);
        wait_done("write_byte1_timeout");

        // W handshake three cycles ahead of AW, slow B.
        aw_delay = 3; w_delay = 0; b_delay = 2;
        issue(1, 2'd2, 32'h8000_0010, 32'hCAFE_F00D, 4'b1111, 32'h0, 7, 0);
        @(negedge clk);
        chk("aww_first_cycle_valids", {30'h0, awvalid, wvalid}, 32'h3);
        @(negedge clk);
        chk("aww_w_dropped_aw_held", {30'h0, awvalid, wvalid}, 32'h2);
        wait_done("write_split_timeout");

        // Request held high across a slow AR.
        aw_delay = 0; b_delay = 0; ar_delay = 5; r_delay = 1; rd_value = 32'h1234_5678;
        ok0 = addr_ok_cnt; ar0 = ar_hs_cnt;
        issue(0, 2'd1, 32'h0000_1002, 32'h0, 4'h0, 32'h1234_5678, 8, 1);
        wait_done("read_hold_timeout");
        data_req = 0;
        chk("hold_single_addr_ok", addr_ok_cnt - ok0, 32'd1);
        chk("hold_single_ar_handshake", ar_hs_cnt - ar0, 32'd1);

        // Reset while waiting for R data.
        ar_delay = 0; r_delay = 4; rd_value = 32'hBAD0_BAD0;
        dn0 = done_cnt;
        issue(0, 2'd2, 32'h2000_0000, 32'h0, 4'h0, 32'hBAD0_BAD0, -1, 0);
        @(posedge clk); #1;
        rst = 1;
        @(posedge clk); #1;
        rst = 0;
        d_q.delete();
        @(negedge clk);
        chk("post_reset_idle", {29'h0, arvalid, rready, data_data_ok}, 32'h0);
        repeat (5) @(negedge clk);
        chk("reset_no_completion", done_cnt - dn0, 32'd0);
        r_delay = 0; rd_value = 32'h0BAD_F00D;
        @(posedge clk); #1;
        issue(0, 2'd2, 32'h2000_0004, 32'h0, 4'h0, 32'h0BAD_F00D, 2, 0);
        wait_done("read_after_reset_timeout");

        // Back-to-back half-word writes.
        issue(1, 2'd1, 32'h0000_0042, 32'hABCD_0000, 4'b1100, 32'h0, 2, 0);
        wait_done("write_half_hi_timeout");
        issue(1, 2'd1, 32'h0000_0040, 32'h0000_ABCD, 4'b0011, 32'h0, 2, 0);
        chk("b2b_accept_gap", acc_gap, 32'd1);
        wait_done("write_half_lo_timeout");

        repeat (3) @(negedge clk);
        chk("queues_drained", ar_q.size() + aw_q.size() + w_q.size() + d_q.size(), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
